xillybus_rd_arbiter: RTL
========================

// Module: xillybus_rd_arbiter
// PURPOSE
//  Shares the single 32-bit host-read stream of xillybus_core (user_r_read_32_*) among N_SRC
//  producer streams. A round-robin scheduler grants one source per burst and emits a header
//  word, then exactly LEN data words. The host demultiplexes using the header.
//  The block sits in the bus_clk domain between the user producers and xillybus_core.
// PARAMETERS
//  N_SRC      4    number of producer sources, 2..8
//  MAX_BURST  64   maximum data words per grant, 1..65535
//  LVL_W      16   width of each source fill-level input
// PORTS
//  bus_clk               in   1          core clock (trn_clk from the PCIe block)
//  trn_reset_n           in   1          asynchronous, active-low reset
//  user_r_read_32_open   in   1          host has the device file open
//  user_r_read_32_rden   in   1          core read strobe (standard, non-FWFT FIFO semantics)
//  user_r_read_32_data   out  32         word, valid in the cycle after an accepted rden
//  user_r_read_32_empty  out  1          no word available
//  user_r_read_32_eof    out  1          end of stream
//  s_valid               in   N_SRC      source i holds a word on s_data
//  s_data                in   32*N_SRC   source i data in slice [32i+31:32i] (FWFT)
//  s_level               in   LVL_W*N_SRC  words guaranteed available at source i
//  s_eof                 in   N_SRC      source i is finished; sticky until reset
//  s_ready               out  N_SRC      pop strobe to source i (at most one bit high)
// BEHAVIOUR
//  Reset (async assert, sync release) sets the following values:
//   - s_ready = 0, user_r_read_32_empty = 1, user_r_read_32_eof = 0, user_r_read_32_data = 0.
//   - FSM = IDLE, round-robin pointer = 0, output FIFO cleared.
//  FSM states are IDLE, ARB, HDR, DATA and DRAIN.
//   - IDLE -> ARB when open=1.
//   - ARB: pick the first i at or after ptr (wrapping) with s_level[i] != 0.
//     - Latch len = min(s_level[i], MAX_BURST) and gnt = i.
//     - Set ptr = i+1 mod N_SRC, then go to HDR.
//     - If no source qualifies, stay in ARB; a grant costs 1 cycle.
//   - HDR: when the output FIFO is not full, push {8'hA5, 5'd0, gnt[2:0], len[15:0]}, then go to DATA.
//   - DATA: each cycle with the FIFO not full and s_valid[gnt]=1:
//     - Assert s_ready[gnt] for that cycle.
//     - Push s_data[gnt] and decrement len.
//     - When len reaches 0 after a push, go to ARB.
//     - If s_valid drops mid-burst, stall without pushing. The burst is never truncated,
//       because level is a guarantee.
//   - DRAIN is entered from any state when open falls.
//     - s_ready is forced to 0 immediately.
//     - The output FIFO is cleared the same cycle; a partial burst is abandoned.
//     - The next IDLE->ARB starts at a fresh header; the remaining source words are
//       kept at the source.
//     - DRAIN -> IDLE on the next cycle.
//  Throughput is 1 word per cycle sustained in DATA; each burst costs 2 overhead cycles.
//  The header is visible on empty=0 two cycles after the ARB decision.
//  The output FIFO is 2 deep.
//   - empty = (count==0).
//   - On rden & !empty, data registers the head word on the next edge.
//   - rden while empty is ignored and data holds its value.
//   - Push and pop in the same cycle on a full FIFO is allowed, and the count stays 2.
//  eof = 1 when all of the following hold: (&s_eof), every s_level is 0, FSM is in ARB,
//  and the FIFO is empty.
//   - eof is registered and holds until open falls.
//   - eof never asserts while a burst is pending.
//  Width rules:
//   - len is 16 bits.
//   - s_level is saturated to MAX_BURST before latching.
//   - Sources with s_level wider than 16 bits are clipped by the min operation.
//  open=0 with rden=1 is ignored.
// STRUCTURE
//  The package xillybus_arb_pkg holds:
//   - HDR_MAGIC = 8'hA5
//   - the FSM state enum
//   - the header field offsets
//  Sub-module xillybus_out_fifo2 is the 2-deep standard-read FIFO with push, pop, full,
//  empty and clear.
//  The round-robin picker is a function: rotate, priority-encode, un-rotate.
// TESTING
//  1. Reset, open=1, s_level[2]=3, valid data A,B,C on source 2, continuous rden:
//     the host reads 32'hA5020003, A, B, C, then empty=1.
//  2. All four sources have s_level=100 and MAX_BURST=64: the grant order is 0,1,2,3,0;
//     each first header has len 16'h0040, and the 0x40-word bursts do not interleave.
//  3. Hold rden=0 with a full FIFO: s_ready stays 0 and no word is lost.
//     Then one rden per cycle gives data in order.
//  4. s_valid[1] drops for 5 cycles mid-burst: no push occurs during the gap,
//     and the burst completes with the exact len.
//  5. Drop open mid-burst: the next cycle has s_ready=0 and empty=1.
//     Reopen: the next word read is a header.
//  6. All s_eof=1 with levels at 0: eof=1 while empty=1.
//     Assert trn_reset_n=0 asynchronously: the outputs return to their reset values
//     without waiting for a clock.

Source files
------------

// File: rtl/xillybus_arb_pkg.sv
// rtl/xillybus_arb_pkg.sv - shared types, header layout and round-robin picker for the read arbiter
package xillybus_arb_pkg;

    localparam logic [7:0] HDR_MAGIC     = 8'hA5;
    localparam int         HDR_MAGIC_LSB = 24;
    localparam int         HDR_GNT_LSB   = 16;
    localparam int         HDR_LEN_LSB   = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_HDR,
        ST_DATA,
        ST_DRAIN
    } arb_state_t;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
    } rr_pick_t;

    // Rotate the request mask so ptr sits at bit 0, take the lowest set bit, then map back.
    function automatic rr_pick_t rr_pick(input logic [7:0] req, input logic [2:0] ptr, input int n);
        rr_pick_t   r;
        logic [7:0] rot;
        logic [2:0] src;
        r.hit = 1'b0;
        r.idx = 3'd0;
        rot   = '0;
        for (int k = 0; k < 8; k++) begin
            if (k < n) begin
                src    = 3'((int'(ptr) + k) % n);
                rot[k] = req[src];
            end
        end
        for (int k = 7; k >= 0; k--) begin
            if (k < n && rot[k]) begin
                r.hit = 1'b1;
                r.idx = 3'((int'(ptr) + k) % n);
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] make_hdr(input logic [2:0] gnt, input logic [15:0] len);
        logic [31:0] h;
        h = '0;
        h[HDR_MAGIC_LSB +: 8] = HDR_MAGIC;
        h[HDR_GNT_LSB +: 3]   = gnt;
        h[HDR_LEN_LSB +: 16]  = len;
        return h;
    endfunction

endpackage

// File: rtl/xillybus_out_fifo2.sv
// rtl/xillybus_out_fifo2.sv - two-entry standard-read output FIFO with synchronous clear
module xillybus_out_fifo2 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        push,
    input  logic [31:0] push_data,
    input  logic        pop,
    output logic [31:0] head,
    output logic        full,
    output logic        empty
);

    logic [31:0] mem0, mem1;
    logic        wr_ptr, rd_ptr;
    logic [1:0]  count;
    logic        push_ok, pop_ok;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign pop_ok  = pop && !empty;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop_ok);
    assign head    = rd_ptr ? mem1 : mem0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem0   <= '0;
            mem1   <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (clear) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) begin
                if (wr_ptr) mem1 <= push_data;
                else        mem0 <= push_data;
                wr_ptr <= ~wr_ptr;
            end
            if (pop_ok) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

endmodule

// File: rtl/xillybus_rd_arbiter.sv
// rtl/xillybus_rd_arbiter.sv - round-robin burst arbiter of N_SRC producers onto the xillybus 32-bit read stream
module xillybus_rd_arbiter
    import xillybus_arb_pkg::*;
#(
    parameter int N_SRC     = 4,
    parameter int MAX_BURST = 64,
    parameter int LVL_W     = 16
) (
    input  logic                   bus_clk,
    input  logic                   trn_reset_n,
    input  logic                   user_r_read_32_open,
    input  logic                   user_r_read_32_rden,
    output logic [31:0]            user_r_read_32_data,
    output logic                   user_r_read_32_empty,
    output logic                   user_r_read_32_eof,
    input  logic [N_SRC-1:0]       s_valid,
    input  logic [32*N_SRC-1:0]    s_data,
    input  logic [LVL_W*N_SRC-1:0] s_level,
    input  logic [N_SRC-1:0]       s_eof,
    output logic [N_SRC-1:0]       s_ready
);

    localparam int               CMP_W   = (LVL_W > 16) ? LVL_W : 16;
    localparam logic [CMP_W-1:0] MAX_LEN = CMP_W'(MAX_BURST);

    arb_state_t         state;
    logic [2:0]         ptr, gnt;
    logic [15:0]        len;
    logic [8*LVL_W-1:0] lvl_all;
    logic [255:0]       data_all;
    logic [7:0]         valid_all, req, ready_all;
    rr_pick_t           pick;
    logic [LVL_W-1:0]   sel_lvl;
    logic [CMP_W-1:0]   lvl_ext;
    logic [15:0]        burst_len;
    logic               cur_valid;
    logic [31:0]        cur_data;
    logic               hdr_push, data_push, push, pop, eof_cond;
    logic [31:0]        push_data, head;
    logic               fifo_full, fifo_empty;
    logic               open;

    assign open = user_r_read_32_open;

    // Widen every per-source bus to 8 lanes so the 3-bit grant can index without range games.
    always_comb begin
        lvl_all                      = '0;
        lvl_all[N_SRC*LVL_W-1:0]     = s_level;
        data_all                     = '0;
        data_all[N_SRC*32-1:0]       = s_data;
        valid_all                    = '0;
        valid_all[N_SRC-1:0]         = s_valid;
        for (int i = 0; i < 8; i++) begin
            req[i] = |lvl_all[i*LVL_W +: LVL_W];
        end
    end

    assign pick      = rr_pick(req, ptr, N_SRC);
    assign sel_lvl   = lvl_all[pick.idx*LVL_W +: LVL_W];
    assign lvl_ext   = CMP_W'(sel_lvl);
    assign burst_len = (lvl_ext > MAX_LEN) ? MAX_LEN[15:0] : lvl_ext[15:0];

    assign cur_valid = valid_all[gnt];
    assign cur_data  = data_all[{gnt, 5'd0} +: 32];

    assign hdr_push  = (state == ST_HDR) && !fifo_full;
    assign data_push = (state == ST_DATA) && !fifo_full && cur_valid;
    assign push      = open && (hdr_push || data_push);
    assign push_data = (state == ST_HDR) ? make_hdr(gnt, len) : cur_data;
    assign pop       = open && user_r_read_32_rden;

    // The pop strobe follows open combinationally so a closing host stops the source at once.
    assign ready_all = (open && data_push) ? (8'd1 << gnt) : 8'd0;
    assign s_ready   = ready_all[N_SRC-1:0];

    assign eof_cond  = (&s_eof) && !(|req) && (state == ST_ARB) && fifo_empty;

    assign user_r_read_32_empty = fifo_empty;

    xillybus_out_fifo2 u_fifo (
        .clk       (bus_clk),
        .rst_n     (trn_reset_n),
        .clear     (!open),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge bus_clk or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            state               <= ST_IDLE;
            ptr                 <= 3'd0;
            gnt                 <= 3'd0;
            len                 <= 16'd0;
            user_r_read_32_data <= 32'd0;
            user_r_read_32_eof  <= 1'b0;
        end else begin
            if (pop && !fifo_empty) user_r_read_32_data <= head;

            if (!open)         user_r_read_32_eof <= 1'b0;
            else if (eof_cond) user_r_read_32_eof <= 1'b1;

            if (state == ST_DRAIN) begin
                state <= ST_IDLE;
            end else if (!open && state != ST_IDLE) begin
                state <= ST_DRAIN;
            end else begin
                case (state)
                    ST_IDLE: if (open) state <= ST_ARB;
                    ST_ARB: begin
                        if (pick.hit) begin
                            gnt   <= pick.idx;
                            len   <= burst_len;
                            ptr   <= (int'(pick.idx) == N_SRC - 1) ? 3'd0 : pick.idx + 3'd1;
                            state <= ST_HDR;
                        end
                    end
                    ST_HDR: if (!fifo_full) state <= ST_DATA;
                    ST_DATA: begin
                        if (data_push) begin
                            len <= len - 16'd1;
                            if (len == 16'd1) state <= ST_ARB;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
